// File: rtl/dff_arb_pkg.sv
// Shared definitions for the two-requester register write arbiter.
//   arb_state_t : arbiter FSM states (IDLE, SERVE0, SERVE1)
//   NUM_REQ     : number of requesters competing for the register
package dff_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } arb_state_t;

   localparam int NUM_REQ = 2;

endpackage

// File: rtl/dff_reg_en.sv
// WIDTH-bit D flip-flop storage register with load enable.
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low clear (Q -> 0)
//   En    : load enable; D is captured on rising Clk when high
//   D     : data to load
//   Q     : stored word
module dff_reg_en #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Q <= '0;
      end else if (En) begin
         Q <= D;
      end
   end

endmodule

// File: rtl/dff_reg_write_arbiter.sv
// Two-requester round-robin arbiter feeding a shared WIDTH-bit register.
//   Clk          : rising-edge clock
//   Rst_n        : asynchronous active-low reset
//   Req0 / Req1  : level write requests
//   Data0 / Data1: write data, held stable while the matching Req is high
//   Gnt0 / Gnt1  : registered grants, one-hot or idle
//   Q            : shared register contents
//   Busy         : high whenever a requester is being served
// A request sampled at edge k yields a grant during cycle k..k+1 and the
// granted word lands in Q at edge k+1.
module dff_reg_write_arbiter
   import dff_arb_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Req0,
   input  logic [WIDTH-1:0] Data0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] Data1,
   output logic             Gnt0,
   output logic             Gnt1,
   output logic [WIDTH-1:0] Q,
   output logic             Busy
);

   arb_state_t         state_reg;
   arb_state_t         state_next;
   logic               last_served_reg;
   logic               last_served_next;
   logic [NUM_REQ-1:0] req;

   assign req = {Req1, Req0};

   // Reset leaves last_served at 1 so requester 0 wins the first tie.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg       <= IDLE;
         last_served_reg <= 1'b1;
      end else begin
         state_reg       <= state_next;
         last_served_reg <= last_served_next;
      end
   end

   // Next state is re-evaluated every cycle, so a grant can move straight
   // to the other requester, or repeat for a requester still holding Req.
   always_comb begin
      state_next       = IDLE;
      last_served_next = last_served_reg;
      Gnt0             = 1'b0;
      Gnt1             = 1'b0;
      Busy             = 1'b0;

      case (req)
         2'b01:   state_next = SERVE0;
         2'b10:   state_next = SERVE1;
         2'b11:   state_next = last_served_reg ? SERVE0 : SERVE1;
         default: state_next = IDLE;
      endcase

      if (state_next == SERVE0) begin
         last_served_next = 1'b0;
      end else if (state_next == SERVE1) begin
         last_served_next = 1'b1;
      end

      Gnt0 = (state_reg == SERVE0);
      Gnt1 = (state_reg == SERVE1);
      Busy = (state_reg != IDLE);
   end

   // The write happens on the edge that ends the grant cycle.
   dff_reg_en #(
      .WIDTH (WIDTH)
   ) u_store (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .En    (Gnt0 | Gnt1),
      .D     (Gnt0 ? Data0 : Data1),
      .Q     (Q)
   );

endmodule
